// File: rtl/minimips_pkg.sv
// Shared definitions for the MiniMIPS program-counter sequencer.
// Holds the sequencer state encoding and the field widths of the
// branch offset and jump target, used by the top and by the next-PC logic.
package minimips_pkg;

    // Default width of the fetch address
    localparam int PC_WIDTH = 32;

    // Width of the signed word offset carried by a branch
    localparam int BRANCH_OFS_W = 16;

    // Width of the word target carried by an absolute jump
    localparam int JUMP_TGT_W = 26;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_e;

endpackage : minimips_pkg

// File: rtl/minimips_next_pc.sv
// Combinational next-PC computation for the MiniMIPS sequencer.
// Picks between increment, PC-relative branch and absolute jump.
// Jump has priority over branch. All arithmetic wraps modulo 2^PC_WIDTH.
module minimips_next_pc
    import minimips_pkg::*;
#(
    parameter int W = minimips_pkg::PC_WIDTH
) (
    input  logic [W-1:0]            pc,
    input  logic [BRANCH_OFS_W-1:0] branch_offset,
    input  logic [JUMP_TGT_W-1:0]   jump_target,
    input  logic                    sel_branch,
    input  logic                    sel_jump,
    output logic [W-1:0]            next_pc
);

    logic [W-1:0] pc_plus_one;
    logic [W-1:0] offset_ext;
    logic [W-1:0] jump_pc;

    // Build the three candidate addresses and select one, jump first
    always_comb begin
        pc_plus_one = pc + W'(1);
        offset_ext  = {{(W - BRANCH_OFS_W){branch_offset[BRANCH_OFS_W-1]}}, branch_offset};
        jump_pc     = pc;
        jump_pc[JUMP_TGT_W-1:0] = jump_target;
        if (sel_jump) begin
            next_pc = jump_pc;
        end else if (sel_branch) begin
            next_pc = pc_plus_one + offset_ext;
        end else begin
            next_pc = pc_plus_one;
        end
    end

endmodule : minimips_next_pc

// File: rtl/minimips_pc_unit.sv
// Program-counter sequencer feeding the MiniMIPS core.
// Runs a RUN/STALL/HALT state machine, counts PC advances with saturation,
// and optionally checks the next PC against the instruction memory size.
// Optional feature macro: MINIMIPS_PC_BOUNDS_CHECK_EN (range check and fault).
module minimips_pc_unit
    import minimips_pkg::*;
#(
    parameter int                   PC_WIDTH   = minimips_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter int                   IMEM_DEPTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [BRANCH_OFS_W-1:0] branch_offset,
    input  logic                    jump,
    input  logic [JUMP_TGT_W-1:0]   jump_target,
    input  logic                    halt_req,
    output logic [PC_WIDTH-1:0]     program_counter,
    output logic                    pc_valid,
    output logic                    halted,
    output logic                    fault,
    output logic [31:0]             instr_count
);

`ifdef MINIMIPS_PC_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [PC_WIDTH-1:0] IMEM_LIMIT = PC_WIDTH'(IMEM_DEPTH);

    pc_state_e              state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic                   pc_valid_q, pc_valid_d;
    logic                   halted_q, halted_d;
    logic                   fault_q, fault_d;
    logic [31:0]            count_q, count_d;
    logic [PC_WIDTH-1:0]    next_pc;

    minimips_next_pc #(
        .W (PC_WIDTH)
    ) u_next_pc (
        .pc            (pc_q),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .sel_branch    (branch_taken),
        .sel_jump      (jump),
        .next_pc       (next_pc)
    );

    // Next-state decode: halt beats stall, stall beats any PC advance;
    // leaving STALL advances on that same edge so a k-cycle stall holds k cycles
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        count_d    = count_q;
        if (state_q != ST_HALT) begin
            if (halt_req) begin
                state_d    = ST_HALT;
                pc_valid_d = 1'b0;
                halted_d   = 1'b1;
            end else if (stall) begin
                state_d = ST_STALL;
            end else if (BOUNDS_EN && (next_pc >= IMEM_LIMIT)) begin
                state_d    = ST_HALT;
                pc_valid_d = 1'b0;
                halted_d   = 1'b1;
                fault_d    = 1'b1;
            end else begin
                state_d = ST_RUN;
                pc_d    = next_pc;
                if (count_q != 32'hFFFF_FFFF) begin
                    count_d = count_q + 32'd1;
                end
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    assign program_counter = pc_q;
    assign pc_valid        = pc_valid_q;
    assign halted          = halted_q;
    assign fault           = fault_q;
    assign instr_count     = count_q;

endmodule : minimips_pc_unit

// File: tb/tb_minimips_pc_unit.sv
// Directed self-checking bench for minimips_pc_unit.
// Expected values are hand-computed; the bounds-check outcome follows
// MINIMIPS_PC_BOUNDS_CHECK_EN when the bench is built with it.
module tb_minimips_pc_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        halt_req;
    logic [31:0] program_counter;
    logic        pc_valid;
    logic        halted;
    logic        fault;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    minimips_pc_unit #(
        .PC_WIDTH   (32),
        .RESET_PC   (32'd0),
        .IMEM_DEPTH (32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_offset   (branch_offset),
        .jump            (jump),
        .jump_target     (jump_target),
        .halt_req        (halt_req),
        .program_counter (program_counter),
        .pc_valid        (pc_valid),
        .halted          (halted),
        .fault           (fault),
        .instr_count     (instr_count)
    );

    // Free-running clock, period 10
    always #5 clock = ~clock;

    // Advance one rising edge and sample 1 time unit after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advance n rising edges
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drive all control inputs in one go
    task automatic apply_stimulus(input logic rst, input logic stl, input logic br,
                                  input logic [15:0] ofs, input logic jmp,
                                  input logic [25:0] tgt, input logic hlt);
        reset         = rst;
        stall         = stl;
        branch_taken  = br;
        branch_offset = ofs;
        jump          = jmp;
        jump_target   = tgt;
        halt_req      = hlt;
    endtask

    // One comparison with its own assertion
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check every output against one expected set
    task automatic check_all(input string tag, input logic [31:0] exp_pc,
                             input logic exp_valid, input logic exp_halted,
                             input logic exp_fault, input logic [31:0] exp_count);
        check_output({tag, ".pc"},     program_counter,        exp_pc);
        check_output({tag, ".valid"},  {31'd0, pc_valid},      {31'd0, exp_valid});
        check_output({tag, ".halted"}, {31'd0, halted},        {31'd0, exp_halted});
        check_output({tag, ".fault"},  {31'd0, fault},         {31'd0, exp_fault});
        check_output({tag, ".count"},  instr_count,            exp_count);
    endtask

    // Reset for one edge, then release with all controls idle
    task automatic do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
        step();
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
    endtask

    initial begin
        $display("[TB] start");
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
        run_cycles(2);
        check_all("reset", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);

        // Free run 0..29
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
        for (int i = 1; i <= 29; i++) begin
            step();
            check_output("run.pc", program_counter, 32'(i));
        end
        check_all("run29", 32'd29, 1'b1, 1'b0, 1'b0, 32'd29);

        // Up to the last valid word, then one more increment
        run_cycles(2);
        check_all("run31", 32'd31, 1'b1, 1'b0, 1'b0, 32'd31);
        step();
`ifdef MINIMIPS_PC_BOUNDS_CHECK_EN
        check_all("bound", 32'd31, 1'b0, 1'b1, 1'b1, 32'd31);
`else
        check_all("bound", 32'd32, 1'b1, 1'b0, 1'b0, 32'd32);
`endif

        // Branch -3 at PC=5 then +10 at PC=5
        do_reset();
        check_all("rst2", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        run_cycles(5);
        check_output("pre_br.pc", program_counter, 32'd5);
        apply_stimulus(1'b0, 1'b0, 1'b1, 16'hFFFD, 1'b0, 26'd0, 1'b0);
        step();
        check_all("br_neg", 32'd3, 1'b1, 1'b0, 1'b0, 32'd6);
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
        run_cycles(2);
        check_output("pre_br2.pc", program_counter, 32'd5);
        apply_stimulus(1'b0, 1'b0, 1'b1, 16'd10, 1'b0, 26'd0, 1'b0);
        step();
        check_all("br_pos", 32'd16, 1'b1, 1'b0, 1'b0, 32'd9);

        // Jump and branch together at PC=7: jump wins
        do_reset();
        run_cycles(7);
        check_output("pre_jmp.pc", program_counter, 32'd7);
        apply_stimulus(1'b0, 1'b0, 1'b1, 16'd5, 1'b1, 26'd20, 1'b0);
        step();
        check_all("jmp", 32'd20, 1'b1, 1'b0, 1'b0, 32'd8);

        // Three-cycle stall at PC=4
        do_reset();
        run_cycles(4);
        check_output("pre_stall.pc", program_counter, 32'd4);
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("stall", 32'd4, 1'b1, 1'b0, 1'b0, 32'd4);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
        step();
        check_all("unstall", 32'd5, 1'b1, 1'b0, 1'b0, 32'd5);

        // Halt at PC=9; halt beats stall and jump, and only reset leaves
        do_reset();
        run_cycles(9);
        check_output("pre_halt.pc", program_counter, 32'd9);
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 26'd3, 1'b1);
        step();
        check_all("halt", 32'd9, 1'b0, 1'b1, 1'b0, 32'd9);
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'd3, 1'b0);
        run_cycles(2);
        check_all("halt_hold", 32'd9, 1'b0, 1'b1, 1'b0, 32'd9);
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 26'd3, 1'b1);
        step();
        check_all("halt_rst", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);

        // Reset in the middle of a stall
        apply_stimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
        run_cycles(3);
        apply_stimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
        run_cycles(2);
        check_all("stall_pre_rst", 32'd3, 1'b1, 1'b0, 1'b0, 32'd3);
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0);
        step();
        check_all("stall_rst", 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);

        // Negative branch from PC=0 wraps below zero
        apply_stimulus(1'b0, 1'b0, 1'b1, 16'hFFFD, 1'b0, 26'd0, 1'b0);
        step();
`ifdef MINIMIPS_PC_BOUNDS_CHECK_EN
        check_all("wrap", 32'd0, 1'b0, 1'b1, 1'b1, 32'd0);
`else
        check_all("wrap", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_minimips_pc_unit
